// File: rtl/cs_arith_pkg.sv
// Shared segment geometry for the 32-bit carry-select adder/subtractor family.
package cs_arith_pkg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEG_NUM = 6;
  localparam int unsigned SEG_W   [SEG_NUM] = '{3, 4, 5, 6, 7, 7};
  localparam int unsigned SEG_LSB [SEG_NUM] = '{0, 3, 7, 12, 18, 25};
endpackage

// File: rtl/cs_seg_sub.sv
// One carry-select segment: dual carry chains (cin=0/1), selected by the incoming carry.
module cs_seg_sub #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] nb,
  input  logic         cin,
  output logic [W-1:0] diff,
  output logic         cout
);
  logic [W-1:0] g, p, c0, c1, csel;

  assign g = a & nb;
  assign p = a | nb;

  always_comb begin
    c0 = '0;
    c1 = '0;
    c0[0] = g[0];
    c1[0] = g[0] | p[0];
    for (int unsigned i = 1; i < W; i++) begin
      c0[i] = g[i] | (p[i] & c0[i-1]);
      c1[i] = g[i] | (p[i] & c1[i-1]);
    end
  end

  assign csel = cin ? c1 : c0;
  assign diff = a ^ nb ^ {csel[W-2:0], cin};
  assign cout = csel[W-1];
endmodule

// File: rtl/cs_sub32_pipe.sv
// Two-stage 32-bit carry-select subtractor (a - b - bin) with elastic valid/ready.
// Define CS_SUB_FLAGS_EN to add registered ovf/zero flag outputs.
module cs_sub32_pipe
  import cs_arith_pkg::*;
#(
  parameter int unsigned SPLIT_SEG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              out_valid,
`ifdef CS_SUB_FLAGS_EN
  output logic              ovf,
  output logic              zero,
`endif
  input  logic              out_ready
);
  if (SPLIT_SEG < 1 || SPLIT_SEG > 5) begin : g_bad_split
    $fatal(1, "cs_sub32_pipe: SPLIT_SEG must be in 1..5");
  end

  localparam int unsigned LO_W = SEG_LSB[SPLIT_SEG];
  localparam int unsigned HI_W = DATA_W - LO_W;

  logic [DATA_W-1:0] nb;
  logic [DATA_W-1:0] seg_diff;
  logic [DATA_W-1:0] diff_nxt;
  logic              s1_valid, s2_valid, s1_en, s2_en;
  logic [LO_W-1:0]   s1_lo;
  logic [HI_W-1:0]   s1_a_hi, s1_nb_hi;
  logic              s1_c;
`ifdef CS_SUB_FLAGS_EN
  logic              s1_a31, s1_b31;
`endif

  assign nb = ~b;

  // Lower segments read live operands; upper segments read the stage 1 slices,
  // with the registered carry restarting the select chain at the split point.
  for (genvar i = 0; i < SEG_NUM; i++) begin : g_seg
    localparam int unsigned W   = SEG_W[i];
    localparam int unsigned LSB = SEG_LSB[i];
    logic [W-1:0] sa, snb;
    logic         ci, co;

    if (i < SPLIT_SEG) begin : g_s1
      assign sa  = a[LSB +: W];
      assign snb = nb[LSB +: W];
    end else begin : g_s2
      assign sa  = s1_a_hi[LSB-LO_W +: W];
      assign snb = s1_nb_hi[LSB-LO_W +: W];
    end

    if (i == 0) begin : g_c0
      assign ci = ~bin;
    end else if (i == SPLIT_SEG) begin : g_csplit
      assign ci = s1_c;
    end else begin : g_cchain
      assign ci = g_seg[i-1].co;
    end

    cs_seg_sub #(.W(W)) u_seg (
      .a    (sa),
      .nb   (snb),
      .cin  (ci),
      .diff (seg_diff[LSB +: W]),
      .cout (co)
    );
  end

  assign diff_nxt  = {seg_diff[DATA_W-1:LO_W], s1_lo};
  assign s2_en     = ~s2_valid | out_ready;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (in_valid && s1_en) begin
      s1_lo    <= seg_diff[LO_W-1:0];
      s1_c     <= g_seg[SPLIT_SEG-1].co;
      s1_a_hi  <= a[DATA_W-1:LO_W];
      s1_nb_hi <= nb[DATA_W-1:LO_W];
`ifdef CS_SUB_FLAGS_EN
      s1_a31   <= a[DATA_W-1];
      s1_b31   <= b[DATA_W-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef CS_SUB_FLAGS_EN
      ovf      <= 1'b0;
      zero     <= 1'b0;
`endif
    end else begin
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) s2_valid <= s1_valid;
      if (s2_en && s1_valid) begin
        diff <= diff_nxt;
        bout <= ~g_seg[SEG_NUM-1].co;
`ifdef CS_SUB_FLAGS_EN
        ovf  <= (s1_a31 != s1_b31) & (diff_nxt[DATA_W-1] != s1_a31);
        zero <= ~|diff_nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_cs_sub32_pipe.sv
// Directed bench for cs_sub32_pipe: reset, arithmetic vectors, backpressure, mid-run reset.
module tb_cs_sub32_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        bin, in_valid, in_ready, out_valid, out_ready, bout;
  logic [31:0] diff;
`ifdef CS_SUB_FLAGS_EN
  logic        ovf, zero;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  cs_sub32_pipe #(.SPLIT_SEG(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid),
`ifdef CS_SUB_FLAGS_EN
    .ovf       (ovf),
    .zero      (zero),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (diff !== 32'h0) begin n_fail++; $display("FAIL reset_diff: got %h expected 00000000", diff); end
    n_checks++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b expected 0", bout); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef CS_SUB_FLAGS_EN
    n_checks++; if ({ovf, zero} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {ovf, zero}); end
`endif
  endtask

  task automatic test_vectors();
    logic [31:0] va [9] = '{32'h5, 32'h0, 32'h1000, 32'h0200_0000, 32'h10, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8};
    logic [31:0] vb [9] = '{32'h3, 32'h1, 32'h1, 32'h1, 32'hF, 32'h1,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8};
    logic        vbi [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
    logic [31:0] ed [9] = '{32'h2, 32'hFFFF_FFFF, 32'hFFF, 32'h01FF_FFFF, 32'h0, 32'h7FFF_FFFF,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic        eb [9] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    logic        eo [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
    logic        ez [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; bin = vbi[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_early_valid: got %b expected 0", i, out_valid); end
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency: got out_valid %b expected 1", i, out_valid); end
      n_checks++; if (diff !== ed[i]) begin n_fail++; $display("FAIL vec%0d_diff: got %h expected %h", i, diff, ed[i]); end
      n_checks++; if (bout !== eb[i]) begin n_fail++; $display("FAIL vec%0d_bout: got %b expected %b", i, bout, eb[i]); end
`ifdef CS_SUB_FLAGS_EN
      n_checks++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL vec%0d_ovf: got %b expected %b", i, ovf, eo[i]); end
      n_checks++; if (zero !== ez[i]) begin n_fail++; $display("FAIL vec%0d_zero: got %b expected %b", i, zero, ez[i]); end
`else
      if (eo[i] === 1'bx || ez[i] === 1'bx) $display("note: unexpected flag table entry %0d", i);
`endif
    end
  endtask

  // k = 1..4: a = 16k+8, b = k-1, bin = 0
  task automatic test_backpressure();
    logic [31:0] exp_d [4] = '{32'd24, 32'd39, 32'd54, 32'd69};
    logic [31:0] held_d = '0;
    logic        held = 1'b0;
    int tx = 0;
    int rx = 0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 3);
      in_valid  = (tx < 4);
      a = 32'(16 * (tx + 1) + 8); b = 32'(tx); bin = 1'b0;
      #1;
      if (held && out_valid) begin
        n_checks++; if (diff !== held_d) begin n_fail++; $display("FAIL bp_hold_stable: got %h expected %h", diff, held_d); end
      end
      if (c == 2) begin
        n_checks++; if (in_ready !== 1'b0 || tx != 2) begin n_fail++; $display("FAIL bp_stall: got in_ready %b after %0d accepted, expected 0 after 2", in_ready, tx); end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (diff !== exp_d[rx] || bout !== 1'b0) begin n_fail++; $display("FAIL bp_result%0d: got %h/%b expected %h/0", rx, diff, bout, exp_d[rx]); end
        rx++;
      end
      held   = out_valid && !out_ready;
      held_d = diff;
      if (in_valid && in_ready) tx++;
    end
    n_checks++; if (rx != 4) begin n_fail++; $display("FAIL bp_count: got %0d results expected 4", rx); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h55; b = 32'h11; bin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_full: got out_valid %b in_ready %b expected 1 0", out_valid, in_ready); end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (diff !== 32'h0 || bout !== 1'b0) begin n_fail++; $display("FAIL mr_diff: got %h/%b expected 00000000/0", diff, bout); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_stale: got out_valid %b expected 0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
